// File: rtl/mdu_ctl_pkg.sv
// Shared opcodes, FSM states and decode helpers for the multiply/divide unit.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_ctl_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // Reserved codes (and the accumulate ops when not built in) collapse to MD_NONE.
    function automatic logic [3:0] md_decode(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op <= MD_MSUBU) ? op : MD_NONE;
`else
        return (op <= MD_MTLO) ? op : MD_NONE;
`endif
    endfunction

    function automatic logic md_is_signed(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

endpackage

// File: rtl/mdu_ctl_if.sv
// Pipeline-side bundle between the E stage and the multiply/divide controller.
interface mdu_ctl_if;

    logic [3:0]  md_op;
    logic        flush;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    modport master (
        output md_op, flush, rs_val, rt_val,
        input  busy, stall_req, md_rdata, hi, lo, done
    );

    modport slave (
        input  md_op, flush, rs_val, rt_val,
        output busy, stall_req, md_rdata, hi, lo, done
    );

endinterface

// File: rtl/mdu_ctl_arith.sv
// Combinational 32x32 product and quotient/remainder, signed or unsigned.
module mdu_arith (
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Divide on magnitudes, then fix signs: quotient truncates toward zero and
    // the remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
    always_comb begin
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_ext = {{32{a_neg}}, a};
        b_ext = {{32{b_neg}}, b};
        prod  = a_ext * b_ext;
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
        r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
    end

endmodule

// File: rtl/mdu_ctl.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO, with MF/MT access and stall request.
// Define MDU_MADD_EN to add multiply-accumulate/subtract ops on the MUL path.
module mdu_ctl
    import mdu_ctl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_ctl_if.slave bus
);

    localparam int CNT_W = 16;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [3:0]  op_dec;
    logic [3:0]  eff;
    logic        busy;
    logic        stall;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    mdu_arith u_arith (
        .is_signed (md_is_signed(op_dec)),
        .a         (bus.rs_val),
        .b         (bus.rt_val),
        .prod      (prod),
        .quot      (quot),
        .rem       (rem)
    );

    // Results are captured at issue; HI/LO only change on the final count.
    always_comb begin
        op_dec    = md_decode(bus.md_op);
        busy      = (state_q != ST_IDLE);
        stall     = busy && (op_dec != MD_NONE);
        eff       = (bus.flush || stall) ? MD_NONE : op_dec;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (eff)
                    MD_MULT, MD_MULTU: begin
                        {pend_hi_d, pend_lo_d} = prod;
                        dz_d    = 1'b0;
                        cnt_d   = CNT_W'(MULT_CYCLES - 1);
                        state_d = ST_MUL;
                    end
`ifdef MDU_MADD_EN
                    MD_MADD, MD_MADDU: begin
                        {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod;
                        dz_d    = 1'b0;
                        cnt_d   = CNT_W'(MULT_CYCLES - 1);
                        state_d = ST_MUL;
                    end
                    MD_MSUB, MD_MSUBU: begin
                        {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod;
                        dz_d    = 1'b0;
                        cnt_d   = CNT_W'(MULT_CYCLES - 1);
                        state_d = ST_MUL;
                    end
`endif
                    MD_DIV, MD_DIVU: begin
                        pend_hi_d = rem;
                        pend_lo_d = quot;
                        dz_d      = (bus.rt_val == 32'd0);
                        cnt_d     = CNT_W'(DIV_CYCLES - 1);
                        state_d   = ST_DIV;
                    end
                    MD_MTHI: hi_d = bus.rs_val;
                    MD_MTLO: lo_d = bus.rs_val;
                    default: ;
                endcase
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == '0) begin
                    if (!dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.stall_req = stall;
    assign bus.md_rdata  = (op_dec == MD_MFHI) ? hi_q :
                           (op_dec == MD_MFLO) ? lo_q : 32'd0;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mdu_ctl.sv
// Self-checking bench for mdu_ctl: cycle-level reference model plus directed literal checks.
module tb_mdu_ctl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   mdu_ctl_if bus ();

   mdu_ctl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model state: remaining cycles of the op in flight and the 64-bit result it will commit.
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   int          m_rem = 0;
   logic [63:0] m_pend = '0;
   logic        m_dz = 1'b0;
   logic        m_done = 1'b0;

   function automatic logic [3:0] modelDecode(input logic [3:0] op);
      if (op > OP_MSUBU) return OP_NONE;
`ifndef MDU_MADD_EN
      if (op >= OP_MADD) return OP_NONE;
`endif
      return op;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: advances once per rising edge using the inputs presented that cycle.
   always @(posedge clk or negedge rst_n) begin
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub;
      logic [3:0]      op;
      if (!rst_n) begin
         m_hi = '0; m_lo = '0; m_rem = 0; m_pend = '0; m_dz = 1'b0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               if (!m_dz) {m_hi, m_lo} = m_pend;
               m_done = 1'b1;
            end
         end else if (!bus.flush) begin
            op = modelDecode(bus.md_op);
            sa = $signed(bus.rs_val);
            sb = $signed(bus.rt_val);
            ua = {32'd0, bus.rs_val};
            ub = {32'd0, bus.rt_val};
            m_dz = 1'b0;
            case (op)
               OP_MULT:  begin m_pend = sa * sb; m_rem = MULT_N; end
               OP_MULTU: begin m_pend = ua * ub; m_rem = MULT_N; end
               OP_MADD:  begin m_pend = {m_hi, m_lo} + 64'(sa * sb); m_rem = MULT_N; end
               OP_MADDU: begin m_pend = {m_hi, m_lo} + 64'(ua * ub); m_rem = MULT_N; end
               OP_MSUB:  begin m_pend = {m_hi, m_lo} - 64'(sa * sb); m_rem = MULT_N; end
               OP_MSUBU: begin m_pend = {m_hi, m_lo} - 64'(ua * ub); m_rem = MULT_N; end
               OP_DIV: begin
                  m_rem = DIV_N;
                  if (sb == 0) m_dz = 1'b1;
                  else begin
                     sq = sa / sb;
                     sr = sa % sb;
                     m_pend = {sr[31:0], sq[31:0]};
                  end
               end
               OP_DIVU: begin
                  m_rem = DIV_N;
                  if (ub == 0) m_dz = 1'b1;
                  else m_pend = {32'(ua % ub), 32'(ua / ub)};
               end
               OP_MTHI: m_hi = bus.rs_val;
               OP_MTLO: m_lo = bus.rs_val;
               default: ;
            endcase
         end
      end
   end

   // Every-cycle comparison of all outputs against the model, away from the active edge.
   always @(negedge clk) begin
      logic [3:0]  op;
      logic [31:0] exp_rd;
      op = modelDecode(bus.md_op);
      exp_rd = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
      checkOutput("cyc_busy", {31'd0, bus.busy}, {31'd0, m_rem != 0});
      checkOutput("cyc_stall", {31'd0, bus.stall_req}, {31'd0, (m_rem != 0) && (op != OP_NONE)});
      checkOutput("cyc_rdata", bus.md_rdata, exp_rd);
      checkOutput("cyc_hi", bus.hi, m_hi);
      checkOutput("cyc_lo", bus.lo, m_lo);
      checkOutput("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
   end

   task automatic applyStimulus(input logic [3:0] op, input logic fl, input logic [31:0] rs, input logic [31:0] rt);
      bus.md_op = op; bus.flush = fl; bus.rs_val = rs; bus.rt_val = rt;
      @(posedge clk); #1;
      bus.md_op = OP_NONE; bus.flush = 1'b0;
   endtask

   task automatic waitIdle(input int exp_n, input string name);
      int n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         @(posedge clk); #1;
      end
      checkOutput({name, "_busy_cycles"}, n, exp_n);
      checkOutput({name, "_done"}, {31'd0, bus.done}, 32'd1);
   endtask

   task automatic checkHiLo(input string name, input logic [31:0] eh, input logic [31:0] el);
      checkOutput({name, "_hi"}, bus.hi, eh);
      checkOutput({name, "_lo"}, bus.lo, el);
   endtask

   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int n;
      rst_n = 1'b0;
      bus.md_op = OP_NONE; bus.flush = 1'b0; bus.rs_val = '0; bus.rt_val = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checkHiLo("reset", 32'd0, 32'd0);
      checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);

      applyStimulus(OP_MULT, 1'b0, 32'hFFFF_FFFE, 32'd3);
      waitIdle(MULT_N, "mult");
      checkHiLo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      @(posedge clk); #1;
      checkOutput("mult_done_pulse", {31'd0, bus.done}, 32'd0);

      applyStimulus(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2);
      waitIdle(DIV_N, "div");
      checkHiLo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      applyStimulus(OP_DIVU, 1'b0, 32'hFFFF_FFF9, 32'd2);
      waitIdle(DIV_N, "divu");
      checkHiLo("divu", 32'd1, 32'h7FFF_FFFC);
      applyStimulus(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle(DIV_N, "div_ovf");
      checkHiLo("div_ovf", 32'd0, 32'h8000_0000);

      applyStimulus(OP_MTHI, 1'b0, 32'h11, 32'd0);
      applyStimulus(OP_MTLO, 1'b0, 32'h22, 32'd0);
      checkHiLo("mt", 32'h11, 32'h22);
      applyStimulus(OP_DIVU, 1'b0, 32'd5, 32'd0);
      waitIdle(DIV_N, "divz");
      checkHiLo("divz", 32'h11, 32'h22);

      bus.md_op = OP_MULTU; bus.rs_val = 32'h10; bus.rt_val = 32'h10;
      @(posedge clk); #1;
      bus.md_op = OP_MFLO;
      n = 0;
      while (bus.stall_req === 1'b1 && n < 50) begin
         n++;
         @(posedge clk); #1;
      end
      checkOutput("mflo_stall_cycles", n, 32'd5);
      checkOutput("mflo_rdata", bus.md_rdata, 32'h100);
      bus.md_op = OP_NONE;

      applyStimulus(OP_MULT, 1'b1, 32'd7, 32'd6);
      checkOutput("flush_busy", {31'd0, bus.busy}, 32'd0);
      checkHiLo("flush", 32'd0, 32'h100);
      applyStimulus(OP_MULT, 1'b0, 32'd7, 32'd6);
      bus.flush = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.flush = 1'b0;
      waitIdle(MULT_N - 2, "flush_mid");
      checkHiLo("flush_mid", 32'd0, 32'd42);

      applyStimulus(OP_DIV, 1'b0, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      checkHiLo("rst_mid", 32'd0, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checkHiLo("rst_after", 32'd0, 32'd0);

      applyStimulus(4'd13, 1'b0, 32'h55, 32'h66);
      checkOutput("rsvd_busy", {31'd0, bus.busy}, 32'd0);
      applyStimulus(OP_MULT, 1'b0, 32'd3, 32'd4);
      bus.md_op = 4'd15;
      #1 checkOutput("rsvd_stall", {31'd0, bus.stall_req}, 32'd0);
`ifndef MDU_MADD_EN
      bus.md_op = OP_MADDU;
      #1 checkOutput("madd_off_stall", {31'd0, bus.stall_req}, 32'd0);
`endif
      bus.md_op = OP_NONE;
      @(posedge clk); #1;
      waitIdle(MULT_N - 1, "mult_rsvd");
      checkHiLo("mult_rsvd", 32'd0, 32'd12);

`ifdef MDU_MADD_EN
      applyStimulus(OP_MTHI, 1'b0, 32'd0, 32'd0);
      applyStimulus(OP_MTLO, 1'b0, 32'hFFFF_FFFF, 32'd0);
      applyStimulus(OP_MADDU, 1'b0, 32'd1, 32'd1);
      waitIdle(MULT_N, "maddu");
      checkHiLo("maddu", 32'd1, 32'd0);
      applyStimulus(OP_MSUB, 1'b0, 32'hFFFF_FFFF, 32'd1);
      waitIdle(MULT_N, "msub");
      checkHiLo("msub", 32'd1, 32'd1);
`else
      applyStimulus(OP_MADDU, 1'b0, 32'd1, 32'd1);
      checkOutput("madd_off_busy", {31'd0, bus.busy}, 32'd0);
      checkHiLo("madd_off", 32'd0, 32'd12);
`endif

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu_ctl.md
Name: mdu_ctl

Overview:
- Multi-cycle multiply/divide controller for the MIPS pipeline, owning the HI/LO registers.
- Accepts the MD-class instruction currently in the E stage and sequences MULT/DIV over a fixed cycle count.
- Raises a stall request while a later MD instruction reaches E during an operation.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- MULT_CYCLES, 5, cycles from MULT/MULTU issue to HI/LO update (>=1).
- DIV_CYCLES, 10, cycles from DIV/DIVU issue to HI/LO update (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- md_op  in  4  E-stage MD operation code (MD_NONE when the E instruction is not MD class).
- flush  in  1  kill the E-stage instruction this cycle.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- busy  out  1  operation in flight.
- stall_req  out  1  hold D/E and bubble M; combinational.
- md_rdata  out  32  MFHI/MFLO read data; combinational.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- done  out  1  one-cycle pulse in the cycle after HI/LO commit.

Behaviour:
- Reset (async, rst_n low): state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, and internal pending results=0.
- States:
  - IDLE: no operation in flight.
  - MUL: multiply counting down.
  - DIV: divide counting down.
  - busy = (state != IDLE).
- Issue condition: eff = md_op gated by ~flush and ~stall_req.
- IDLE with eff in {MULT,MULTU}:
  - latch product into pend_hi/pend_lo.
  - cnt <= MULT_CYCLES-1; go to MUL.
- IDLE with eff in {DIV,DIVU}:
  - latch quotient into pend_lo and remainder into pend_hi.
  - cnt <= DIV_CYCLES-1; go to DIV.
- MUL/DIV counting: while cnt != 0, decrement cnt each cycle. At cnt == 0:
  - hi <= pend_hi, lo <= pend_lo, state <= IDLE.
  - done is registered and goes high in the following cycle.
- Latency: an issue at edge T commits at edge T+N (N = MULT_CYCLES or DIV_CYCLES). busy is high for N cycles.
- stall_req = busy & (md_op != MD_NONE). Any MD op, including MF/MT, stalls while busy. The flush input does not mask stall_req.
- MTHI/MTLO (eff, IDLE): write rs_val to hi/lo at the clock edge.
- MFHI/MFLO: md_rdata = hi/lo. For any other op, md_rdata = 0.
- Arithmetic:
  - MULT: signed 32x32->64. MULTU: unsigned.
  - DIV: signed, quotient truncates toward zero, remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned.
- Divide by zero: full DIV_CYCLES elapse and done pulses, but hi/lo are left unchanged.
- Flush semantics:
  - flush kills only the E-stage op: no issue and no MT write.
  - An in-flight operation is never aborted by flush; only rst_n aborts it.
- Reset mid-operation: return immediately to IDLE, discard pending results, clear hi/lo.
- Unused/reserved md_op codes are treated as MD_NONE.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Adds MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU.
  - They use MULT_CYCLES and the MUL state.
  - pend = {hi,lo} +/- product, 64-bit wrap, using the {hi,lo} value at issue.
- Undefined: these codes decode as MD_NONE (no stall, no write).

Decomposition:
- Shared header mdu.vh holds:
  - md_op localparams: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - state encodings IDLE=0, MUL=1, DIV=2.
- ctl gains a decoder output driving md_op.
- One sub-module is natural: mdu_arith, a purely combinational 64-bit product / quotient / remainder unit including the signed-division corner cases. mdu_ctl keeps the FSM, counter, and HI/LO registers.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3:
  - busy high for 5 cycles.
  - commit hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - done pulses 1 cycle after commit.
- DIV rs=0xFFFFFFF9 (-7), rt=2:
  - after 10 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFD.
  - DIVU with the same operands gives hi=1, lo=0x7FFFFFFC.
- DIVU 0x5 / 0 after MTHI 0x11, MTLO 0x22:
  - 10 cycles busy, done pulses.
  - hi=0x11, lo=0x22 unchanged.
- MULTU 0x10 x 0x10, then MFLO presented in the next cycle:
  - stall_req held for 5 cycles.
  - md_rdata=0x100 in the first unstalled cycle.
- MULT issued with flush=1: no busy, hi/lo unchanged. Repeat with flush asserted mid-operation: commit still occurs.
- rst_n low during DIV cycle 4: busy=0, hi=lo=0 immediately, no done. With MDU_MADD_EN, MADDU {hi,lo}=0x0_FFFFFFFF plus 1x1 gives hi=1, lo=0.
